// File: rtl/apb_queued_master.sv
// APB4 requester bridge: queues commands in a FIFO, decodes the slave from the upper
// address bits, issues back-to-back transfers and aborts transfers stalled too long.
module apb_queued_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NO_SLAVES  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [NO_SLAVES-1:0]    psel,
    output logic                    penable,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int SEL_W  = (NO_SLAVES > 1) ? $clog2(NO_SLAVES) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_W-1:0]     strb;
        logic [2:0]            prot;
    } cmd_t;

    cmd_t                  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [NO_SLAVES-1:0]  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    cmd_t             req_cmd, head;
    logic [SEL_W-1:0] head_idx;
    logic             head_ok, fifo_empty, push, pop, load;

    assign req_cmd    = {req_addr, req_write, req_wdata, req_strb, req_prot};
    assign head       = fifo_q[rd_ptr_q];
    assign head_idx   = head.addr[ADDR_WIDTH-1 -: SEL_W];
    assign head_ok    = (int'(head_idx) < NO_SLAVES);
    assign fifo_empty = (count_q == '0);
    assign req_ready  = preset_n && (count_q != (PTR_W+1)'(FIFO_DEPTH));
    assign push       = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        pop           = 1'b0;
        load          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        load = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                    // A bad head is left queued so IDLE reports its decode error.
                    if (!fifo_empty && head_ok) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end
                end else if (TIMEOUT > 0 && int'(wait_q) == TIMEOUT - 1) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    wait_d        = '0;
                    state_d       = ST_IDLE;
                end else if (TIMEOUT > 0) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d   = ST_SETUP;
            penable_d = 1'b0;
            wait_d    = '0;
            paddr_d   = head.addr;
            pprot_d   = head.prot;
            pwrite_d  = head.write;
            pwdata_d  = head.write ? head.wdata : '0;
            pstrb_d   = head.write ? head.strb : '0;
            for (int i = 0; i < NO_SLAVES; i++) begin
                psel_d[i] = (int'(head_idx) == i);
            end
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wait_q        <= '0;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wait_q        <= wait_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Storage needs no reset; validity comes from the pointers and count.
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= req_cmd;
        end
    end

    assign busy        = !fifo_empty || (state_q != ST_IDLE);
    assign paddr       = paddr_q;
    assign pprot       = pprot_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
